// File: rtl/alu_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// alu_arbiter_pkg
// Shared definitions for the two-requester ALU arbiter:
//   - ALU op code constants and op width
//   - request record (aluop, a, b, tag)
// Optional build macro used by the importing files: ALU_LOCK_EN
// ---------------------------------------------------------------------------
package alu_arbiter_pkg;

    localparam int unsigned ALUOP_W   = 5;
    // Tag field is sized for the widest supported tag; narrower tags are
    // zero-filled into the low bits. TAG_W must not exceed this.
    localparam int unsigned TAG_W_MAX = 16;

    localparam logic [ALUOP_W-1:0] ADD_OP  = 5'd0;
    localparam logic [ALUOP_W-1:0] ADDU_OP = 5'd1;
    localparam logic [ALUOP_W-1:0] SUBU_OP = 5'd2;
    localparam logic [ALUOP_W-1:0] AND_OP  = 5'd3;
    localparam logic [ALUOP_W-1:0] OR_OP   = 5'd4;
    localparam logic [ALUOP_W-1:0] SLT_OP  = 5'd5;
    localparam logic [ALUOP_W-1:0] LUI_OP  = 5'd6;

    typedef struct packed {
        logic [ALUOP_W-1:0]   aluop;
        logic [31:0]          a;
        logic [31:0]          b;
        logic [TAG_W_MAX-1:0] tag;
    } alu_req_t;

endpackage

// File: rtl/alu_arbiter_picker.sv
// ---------------------------------------------------------------------------
// alu_rr_picker
// Two-input round-robin picker. Produces a one-hot grant when the result slot
// can accept a new op; holds the round-robin pointer (0 = requester 0 next).
// Optional macro ALU_LOCK_EN adds per-requester lock inputs: a locked grant
// makes that requester the owner, and only the owner may be granted until it
// completes a transaction with lock=0.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   req_valid[1:0] requester valids
//   slot_free     result slot can take a new result this cycle
//   req_lock[1:0] (ALU_LOCK_EN only) lock request per requester
//   grant[1:0]    one-hot grant (combinational)
// ---------------------------------------------------------------------------
module alu_rr_picker (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_valid,
    input  logic       slot_free,
`ifdef ALU_LOCK_EN
    input  logic [1:0] req_lock,
`endif
    output logic [1:0] grant
);

    logic       rr_ptr_q, rr_ptr_d;
    logic [1:0] eligible;
`ifdef ALU_LOCK_EN
    logic       owner_valid_q, owner_valid_d;
    logic       owner_q, owner_d;
`endif

    always_comb begin
        // No grant while in reset or while the result slot is blocked.
        eligible = (rst || !slot_free) ? 2'b00 : req_valid;
`ifdef ALU_LOCK_EN
        if (owner_valid_q) begin
            eligible = eligible & (owner_q ? 2'b10 : 2'b01);
        end
`endif
        if (eligible == 2'b11) begin
            grant = rr_ptr_q ? 2'b10 : 2'b01;
        end else begin
            grant = eligible;
        end

        rr_ptr_d = rr_ptr_q;
        if (grant[0]) begin
            rr_ptr_d = 1'b1;
        end else if (grant[1]) begin
            rr_ptr_d = 1'b0;
        end

`ifdef ALU_LOCK_EN
        owner_valid_d = owner_valid_q;
        owner_d       = owner_q;
        // While an owner exists only it can be granted, so re-deriving the
        // owner from every grant both takes and releases ownership.
        if (grant != 2'b00) begin
            owner_d       = grant[1];
            owner_valid_d = grant[1] ? req_lock[1] : req_lock[0];
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q      <= 1'b0;
`ifdef ALU_LOCK_EN
            owner_valid_q <= 1'b0;
            owner_q       <= 1'b0;
`endif
        end else begin
            rr_ptr_q      <= rr_ptr_d;
`ifdef ALU_LOCK_EN
            owner_valid_q <= owner_valid_d;
            owner_q       <= owner_d;
`endif
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
// Shares one combinational ALU between two valid/ready requesters using
// round-robin arbitration; the result is registered into a single output
// slot with its own valid/ready handshake (1-cycle latency, 1 op/cycle).
// Optional macro ALU_LOCK_EN adds req0_lock / req1_lock ownership inputs.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   reqN_valid/ready              requester N handshake (ready = grant)
//   reqN_aluop/a/b/tag            requester N op, operands and tag
//   reqN_lock                     (ALU_LOCK_EN only) take/keep ownership
//   res_valid/ready               result slot handshake
//   res_data/zero/src/tag         result, zero flag, source index, tag
// ---------------------------------------------------------------------------
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int unsigned TAG_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req0_valid,
    output logic               req0_ready,
    input  logic [ALUOP_W-1:0] req0_aluop,
    input  logic [31:0]        req0_a,
    input  logic [31:0]        req0_b,
    input  logic [TAG_W-1:0]   req0_tag,
    input  logic               req1_valid,
    output logic               req1_ready,
    input  logic [ALUOP_W-1:0] req1_aluop,
    input  logic [31:0]        req1_a,
    input  logic [31:0]        req1_b,
    input  logic [TAG_W-1:0]   req1_tag,
`ifdef ALU_LOCK_EN
    input  logic               req0_lock,
    input  logic               req1_lock,
`endif
    output logic               res_valid,
    input  logic               res_ready,
    output logic [31:0]        res_data,
    output logic               res_zero,
    output logic               res_src,
    output logic [TAG_W-1:0]   res_tag
);

    alu_req_t          req0_s, req1_s, sel;
    logic [1:0]        grant;
    logic              slot_free;
    logic [31:0]       alu_out;
    logic              unused_tag;

    logic              res_valid_q, res_valid_d;
    logic [31:0]       res_data_q, res_data_d;
    logic              res_zero_q, res_zero_d;
    logic              res_src_q, res_src_d;
    logic [TAG_W-1:0]  res_tag_q, res_tag_d;

    assign slot_free = !res_valid_q || res_ready;

    alu_rr_picker u_picker (
        .clk       (clk),
        .rst       (rst),
        .req_valid ({req1_valid, req0_valid}),
        .slot_free (slot_free),
`ifdef ALU_LOCK_EN
        .req_lock  ({req1_lock, req0_lock}),
`endif
        .grant     (grant)
    );

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];

    always_comb begin
        req0_s              = '0;
        req0_s.aluop        = req0_aluop;
        req0_s.a            = req0_a;
        req0_s.b            = req0_b;
        req0_s.tag[TAG_W-1:0] = req0_tag;
        req1_s              = '0;
        req1_s.aluop        = req1_aluop;
        req1_s.a            = req1_a;
        req1_s.b            = req1_b;
        req1_s.tag[TAG_W-1:0] = req1_tag;
        sel                 = grant[1] ? req1_s : req0_s;
    end

    // Upper tag bits are always zero-filled padding.
    assign unused_tag = ^sel.tag;

    always_comb begin
        alu_out = '0;
        case (sel.aluop)
            ADD_OP, ADDU_OP: alu_out = sel.a + sel.b;
            SUBU_OP:         alu_out = sel.a - sel.b;
            AND_OP:          alu_out = sel.a & sel.b;
            OR_OP:           alu_out = sel.a | sel.b;
            SLT_OP:          alu_out = {31'b0, ($signed(sel.a) < $signed(sel.b))};
            LUI_OP:          alu_out = {sel.b[15:0], 16'h0000};
            default:         alu_out = '0;
        endcase
    end

    always_comb begin
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_zero_d  = res_zero_q;
        res_src_d   = res_src_q;
        res_tag_d   = res_tag_q;
        if (grant != 2'b00) begin
            res_valid_d = 1'b1;
            res_data_d  = alu_out;
            res_zero_d  = (alu_out == 32'd0);
            res_src_d   = grant[1];
            res_tag_d   = sel.tag[TAG_W-1:0];
        end else if (res_valid_q && res_ready) begin
            res_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_zero_q  <= 1'b0;
            res_src_q   <= 1'b0;
            res_tag_q   <= '0;
        end else begin
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_zero_q  <= res_zero_d;
            res_src_q   <= res_src_d;
            res_tag_q   <= res_tag_d;
        end
    end

    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_zero  = res_zero_q;
    assign res_src   = res_src_q;
    assign res_tag   = res_tag_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_arbiter
// Directed, table-driven bench for alu_arbiter plus hand sequences for
// backpressure release and (with ALU_LOCK_EN) ownership.
// ---------------------------------------------------------------------------
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [4:0]  req0_aluop = '0, req1_aluop = '0;
    logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [3:0]  req0_tag = '0, req1_tag = '0;
`ifdef ALU_LOCK_EN
    logic        req0_lock = 1'b0, req1_lock = 1'b0;
`endif
    logic        res_valid, res_zero, res_src;
    logic        res_ready = 1'b0;
    logic [31:0] res_data;
    logic [3:0]  res_tag;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.TAG_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_aluop (req0_aluop),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_tag   (req0_tag),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_aluop (req1_aluop),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_tag   (req1_tag),
`ifdef ALU_LOCK_EN
        .req0_lock  (req0_lock),
        .req1_lock  (req1_lock),
`endif
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_zero   (res_zero),
        .res_src    (res_src),
        .res_tag    (res_tag)
    );

    typedef struct {
        logic        rst;
        logic        r0v;
        logic [4:0]  op0;
        logic [31:0] a0, b0;
        logic [3:0]  t0;
        logic        r1v;
        logic [4:0]  op1;
        logic [31:0] a1, b1;
        logic [3:0]  t1;
        logic        rr;
        logic [1:0]  exp_rdy;   // {req0_ready, req1_ready} before the edge
        logic        exp_v;
        logic [31:0] exp_d;
        logic        exp_z;
        logic        exp_s;
        logic [3:0]  exp_t;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(
        input logic rs, input logic r0v, input logic [4:0] op0,
        input logic [31:0] a0, input logic [31:0] b0, input logic [3:0] t0,
        input logic r1v, input logic [4:0] op1,
        input logic [31:0] a1, input logic [31:0] b1, input logic [3:0] t1,
        input logic rr, input logic [1:0] rdy, input logic v,
        input logic [31:0] d, input logic z, input logic s, input logic [3:0] t);
        vec_t x;
        x.rst = rs; x.r0v = r0v; x.op0 = op0; x.a0 = a0; x.b0 = b0; x.t0 = t0;
        x.r1v = r1v; x.op1 = op1; x.a1 = a1; x.b1 = b1; x.t1 = t1; x.rr = rr;
        x.exp_rdy = rdy; x.exp_v = v; x.exp_d = d; x.exp_z = z; x.exp_s = s; x.exp_t = t;
        vecs.push_back(x);
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [38:0] res_pack(input logic v, input logic z, input logic s,
                                             input logic [3:0] t, input logic [31:0] d);
        return {v, z, s, t, d};
    endfunction

    initial begin
        // rst, r0: v op a b tag, r1: v op a b tag, res_ready | rdy, v data zero src tag
        // reset state, readies held low during reset
        add(1, 1,5'd1,32'd1,32'd1,4'd1, 1,5'd1,32'd2,32'd2,4'd2, 1, 2'b00, 0,32'd0,0,0,4'd0);
        // single requester: addu 5+7
        add(0, 1,5'd1,32'd5,32'd7,4'd3, 0,5'd0,32'd0,32'd0,4'd0, 1, 2'b10, 1,32'd12,0,0,4'd3);
        // both valid, alternating grants with no bubbles (pointer now at 1)
        add(0, 1,5'd5,32'hFFFFFFFF,32'd1,4'd1, 1,5'd2,32'd3,32'd3,4'd2, 1, 2'b01, 1,32'd0,1,1,4'd2);
        add(0, 1,5'd5,32'hFFFFFFFF,32'd1,4'd1, 1,5'd2,32'd3,32'd3,4'd2, 1, 2'b10, 1,32'd1,0,0,4'd1);
        add(0, 1,5'd5,32'hFFFFFFFF,32'd1,4'd1, 1,5'd2,32'd3,32'd3,4'd2, 1, 2'b01, 1,32'd0,1,1,4'd2);
        add(0, 1,5'd5,32'hFFFFFFFF,32'd1,4'd1, 1,5'd2,32'd3,32'd3,4'd2, 1, 2'b10, 1,32'd1,0,0,4'd1);
        // backpressure for three cycles: no grants, result stable
        add(0, 1,5'd3,32'hF0F0,32'hFF00,4'd5, 1,5'd4,32'd1,32'd2,4'd6, 0, 2'b00, 1,32'd1,0,0,4'd1);
        add(0, 1,5'd3,32'hF0F0,32'hFF00,4'd5, 1,5'd4,32'd1,32'd2,4'd6, 0, 2'b00, 1,32'd1,0,0,4'd1);
        add(0, 1,5'd3,32'hF0F0,32'hFF00,4'd5, 1,5'd4,32'd1,32'd2,4'd6, 0, 2'b00, 1,32'd1,0,0,4'd1);
        // release: grant in the same cycle (pointer at 1), or 1|2
        add(0, 1,5'd3,32'hF0F0,32'hFF00,4'd5, 1,5'd4,32'd1,32'd2,4'd6, 1, 2'b01, 1,32'd3,0,1,4'd6);
        add(0, 1,5'd3,32'hF0F0,32'hFF00,4'd5, 0,5'd4,32'd1,32'd2,4'd6, 1, 2'b10, 1,32'hF000,0,0,4'd5);
        // wrap-around add, lui, undefined op
        add(0, 1,5'd0,32'hFFFFFFFF,32'd1,4'd7, 0,5'd0,32'd0,32'd0,4'd0, 1, 2'b10, 1,32'd0,1,0,4'd7);
        add(0, 0,5'd0,32'd0,32'd0,4'd0, 1,5'd6,32'd0,32'h1234,4'd8, 1, 2'b01, 1,32'h12340000,0,1,4'd8);
        add(0, 1,5'd9,32'd5,32'd6,4'd9, 0,5'd0,32'd0,32'd0,4'd0, 1, 2'b10, 1,32'd0,1,0,4'd9);
        // drain, then idle with changing payload: fields hold
        add(0, 0,5'd1,32'd3,32'd4,4'd1, 0,5'd1,32'd5,32'd6,4'd2, 1, 2'b00, 0,32'd0,1,0,4'd9);
        add(0, 0,5'd2,32'hFF,32'd1,4'd4, 0,5'd4,32'd7,32'd8,4'd5, 0, 2'b00, 0,32'd0,1,0,4'd9);
        // load a result and move the pointer to 1, then reset mid-stream
        add(0, 1,5'd1,32'd1,32'd1,4'd10, 0,5'd0,32'd0,32'd0,4'd0, 1, 2'b10, 1,32'd2,0,0,4'd10);
        add(1, 1,5'd1,32'd1,32'd1,4'd10, 1,5'd2,32'd10,32'd3,4'd12, 0, 2'b00, 0,32'd0,0,0,4'd0);
        add(0, 1,5'd1,32'd4,32'd4,4'd11, 1,5'd2,32'd10,32'd3,4'd12, 1, 2'b10, 1,32'd8,0,0,4'd11);
        add(0, 1,5'd1,32'd4,32'd4,4'd11, 1,5'd2,32'd10,32'd3,4'd12, 1, 2'b01, 1,32'd7,0,1,4'd12);
        // subu wrap and signed slt edges
        add(0, 1,5'd2,32'd0,32'd1,4'd13, 0,5'd0,32'd0,32'd0,4'd0, 1, 2'b10, 1,32'hFFFFFFFF,0,0,4'd13);
        add(0, 0,5'd0,32'd0,32'd0,4'd0, 1,5'd5,32'd1,32'h80000000,4'd14, 1, 2'b01, 1,32'd0,1,1,4'd14);
        add(0, 0,5'd0,32'd0,32'd0,4'd0, 1,5'd5,32'h80000000,32'd0,4'd15, 1, 2'b01, 1,32'd1,0,1,4'd15);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst        = vecs[i].rst;
            req0_valid = vecs[i].r0v; req0_aluop = vecs[i].op0;
            req0_a     = vecs[i].a0;  req0_b     = vecs[i].b0; req0_tag = vecs[i].t0;
            req1_valid = vecs[i].r1v; req1_aluop = vecs[i].op1;
            req1_a     = vecs[i].a1;  req1_b     = vecs[i].b1; req1_tag = vecs[i].t1;
            res_ready  = vecs[i].rr;
            #1;
            chk($sformatf("vec%0d_ready", i), {62'd0, req0_ready, req1_ready},
                {62'd0, vecs[i].exp_rdy});
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_result", i),
                {25'd0, res_pack(res_valid, res_zero, res_src, res_tag, res_data)},
                {25'd0, res_pack(vecs[i].exp_v, vecs[i].exp_z, vecs[i].exp_s,
                                 vecs[i].exp_t, vecs[i].exp_d)});
        end

        // Slot full (holds 1 from the last vector): held off, then granted on release.
        @(negedge clk);
        req0_valid = 1'b1; req0_aluop = 5'd1; req0_a = 32'd2; req0_b = 32'd3; req0_tag = 4'd1;
        req1_valid = 1'b0; res_ready = 1'b0;
        #1;
        chk("held_ready0", {63'd0, req0_ready}, 64'd0);
        @(posedge clk); #1;
        chk("held_data", {32'd0, res_data}, 64'd1);
        @(negedge clk);
        res_ready = 1'b1;
        begin
            int waited;
            waited = 0;
            #1;
            while (!req0_ready && waited < 4) begin
                @(negedge clk); #1;
                waited++;
            end
            chk("release_grant_delay", waited, 64'd0);
        end
        @(posedge clk); #1;
        chk("release_result", {25'd0, res_pack(res_valid, res_zero, res_src, res_tag, res_data)},
            {25'd0, res_pack(1'b1, 1'b0, 1'b0, 4'd1, 32'd5)});
        @(negedge clk);
        req0_valid = 1'b0; res_ready = 1'b1;
        @(posedge clk); #1;
        chk("drain_valid", {63'd0, res_valid}, 64'd0);

`ifdef ALU_LOCK_EN
        @(negedge clk);
        rst = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0; res_ready = 1'b1;
        req1_valid = 1'b1; req1_lock = 1'b1; req1_aluop = 5'd1; req1_a = 32'd1; req1_b = 32'd1;
        #1;
        chk("lock_take", {62'd0, req0_ready, req1_ready}, 64'd1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            req0_valid = 1'b1; req1_valid = 1'b1; req1_lock = 1'b1;
            #1;
            chk($sformatf("lock_hold%0d", k), {62'd0, req0_ready, req1_ready}, 64'd1);
        end
        @(negedge clk);
        req1_valid = 1'b0;
        #1;
        chk("lock_owner_idle", {62'd0, req0_ready, req1_ready}, 64'd0);
        @(negedge clk);
        req1_valid = 1'b1; req1_lock = 1'b0;
        #1;
        chk("lock_release", {62'd0, req0_ready, req1_ready}, 64'd1);
        @(negedge clk);
        #1;
        chk("lock_after", {62'd0, req0_ready, req1_ready}, 64'd2);
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
